// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing generator: free-running x/y counters with registered
// syncs, active flag and line/frame start pulses, all describing the same (x,y).
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_NEG = 1'b1
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_EN,
  output logic       o_hSync,
  output logic       o_vSync,
  output logic [9:0] o_x_pos,
  output logic [9:0] o_y_pos,
  output logic       o_active,
  output logic       o_line_start,
  output logic       o_frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  HLast      = 10'(HTotal - 1);
  localparam logic [9:0]  VLast      = 10'(VTotal - 1);
  // 11-bit bounds so a sync region ending exactly at 1024 still decodes correctly
  localparam logic [10:0] HAct       = 11'(H_ACTIVE);
  localparam logic [10:0] VAct       = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [10:0] x_ext, y_ext;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (i_EN) begin
      if (x_q == HLast) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == VLast) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decode from the next position so every registered output matches x_q/y_q.
    x_ext    = {1'b0, x_d};
    y_ext    = {1'b0, y_d};
    hsync_d  = ((x_ext >= HSyncStart) && (x_ext < HSyncEnd)) ^ SYNC_NEG;
    vsync_d  = ((y_ext >= VSyncStart) && (y_ext < VSyncEnd)) ^ SYNC_NEG;
    active_d = (x_ext < HAct) && (y_ext < VAct);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= SYNC_NEG;
      vsync_q       <= SYNC_NEG;
      active_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_x_pos       = x_q;
  assign o_y_pos       = y_q;
  assign o_hSync       = hsync_q;
  assign o_vSync       = vsync_q;
  assign o_active      = active_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a tiny 12x7 active-high instance,
// both driven by the same reset/enable and checked against a cycle scoreboard and vectors.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    string name;
    int    d;
    int    run;
    out_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic       hs0, vs0, act0, ls0, fs0, hs1, vs1, act1, ls1, fs1;
  logic [9:0] x0, y0, x1, y1;
  out_t       got0, got1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_big (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .o_hSync(hs0), .o_vSync(vs0), .o_x_pos(x0),
    .o_y_pos(y0), .o_active(act0), .o_line_start(ls0), .o_frame_start(fs0)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_NEG(1'b0)
  ) u_small (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .o_hSync(hs1), .o_vSync(vs1), .o_x_pos(x1),
    .o_y_pos(y1), .o_active(act1), .o_line_start(ls1), .o_frame_start(fs1)
  );

  assign got0 = '{x: x0, y: y0, hs: hs0, vs: vs0, act: act0, ls: ls0, fs: fs0};
  assign got1 = '{x: x1, y: y1, hs: hs1, vs: vs1, act: act1, ls: ls1, fs: fs1};

  // Reference timing for the two instances
  int HA[2] = '{640, 8};
  int HF[2] = '{16, 1};
  int HS[2] = '{96, 2};
  int HB[2] = '{48, 1};
  int VA[2] = '{480, 4};
  int VF[2] = '{10, 1};
  int VS[2] = '{2, 1};
  int VB[2] = '{33, 1};
  bit NEG[2] = '{1'b1, 1'b0};

  int mx[2], my[2];
  bit mls[2], mfs[2];
  out_t q0[$], q1[$];

  function automatic out_t model_out(input int d);
    out_t o;
    o.x   = 10'(mx[d]);
    o.y   = 10'(my[d]);
    o.hs  = ((mx[d] >= HA[d] + HF[d]) && (mx[d] < HA[d] + HF[d] + HS[d])) ^ NEG[d];
    o.vs  = ((my[d] >= VA[d] + VF[d]) && (my[d] < VA[d] + VF[d] + VS[d])) ^ NEG[d];
    o.act = (mx[d] < HA[d]) && (my[d] < VA[d]);
    o.ls  = mls[d];
    o.fs  = mfs[d];
    return o;
  endfunction

  task automatic model_step(input int d, input bit r, input bit e);
    int ht, vt;
    ht = HA[d] + HF[d] + HS[d] + HB[d];
    vt = VA[d] + VF[d] + VS[d] + VB[d];
    mls[d] = 1'b0;
    mfs[d] = 1'b0;
    if (r) begin
      mx[d] = 0;
      my[d] = 0;
    end else if (e) begin
      mx[d] = mx[d] + 1;
      if (mx[d] == ht) begin
        mx[d]  = 0;
        mls[d] = 1'b1;
        my[d]  = my[d] + 1;
        if (my[d] == vt) begin
          my[d]  = 0;
          mfs[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
               name, act.x, act.y, act.hs, act.vs, act.act, act.ls, act.fs,
               exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, push model expectation, then pop and compare after the edge.
  task automatic tick(input bit r, input bit e);
    rst = r;
    en  = e;
    for (int d = 0; d < 2; d++) model_step(d, r, e);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(posedge clk);
    #1;
    check("sb_big", got0, q0.pop_front());
    check("sb_small", got1, q1.pop_front());
  endtask

  function automatic vec_t mkv(input string n, input int d, input int run, input int x,
                               input int y, input bit h, input bit v, input bit a,
                               input bit l, input bit f);
    vec_t r;
    r.name = n;
    r.d    = d;
    r.run  = run;
    r.e    = '{x: 10'(x), y: 10'(y), hs: h, vs: v, act: a, ls: l, fs: f};
    return r;
  endfunction

  vec_t vecs[$];
  int   hs_low, act_low, ls_cnt, fs_cnt, vs_hi, y_max;

  initial begin
    //                 name          d  run   x    y  hs vs act ls fs
    vecs.push_back(mkv("b_reset",    0,   0,   0,   0, 1, 1, 1, 0, 0));
    vecs.push_back(mkv("b_first",    0,   1,   1,   0, 1, 1, 1, 0, 0));
    vecs.push_back(mkv("b_x639",     0, 639, 639,   0, 1, 1, 1, 0, 0));
    vecs.push_back(mkv("b_x640",     0, 640, 640,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv("b_hs_on",    0, 656, 656,   0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv("b_hs_last",  0, 751, 751,   0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv("b_hs_off",   0, 752, 752,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv("b_x799",     0, 799, 799,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv("b_wrap",     0, 800,   0,   1, 1, 1, 1, 1, 0));
    vecs.push_back(mkv("b_after",    0, 801,   1,   1, 1, 1, 1, 0, 0));
    vecs.push_back(mkv("s_reset",    1,   0,   0,   0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv("s_hs_on",    1,   9,   9,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv("s_hs_off",   1,  11,  11,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("s_wrap",     1,  12,   0,   1, 0, 0, 1, 1, 0));
    vecs.push_back(mkv("s_vs_on",    1,  60,   0,   5, 0, 1, 0, 1, 0));
    vecs.push_back(mkv("s_last",     1,  83,  11,   6, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("s_frame",    1,  84,   0,   0, 0, 0, 1, 1, 1));
    vecs.push_back(mkv("s_after",    1,  85,   1,   0, 0, 0, 1, 0, 0));

    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      tick(1'b1, 1'b1);
      repeat (vecs[i].run) tick(1'b0, 1'b1);
      check(vecs[i].name, (vecs[i].d == 0) ? got0 : got1, vecs[i].e);
    end

    // One full line of the default timing
    tick(1'b1, 1'b1);
    hs_low = 0; act_low = 0; ls_cnt = 0;
    repeat (800) begin
      tick(1'b0, 1'b1);
      hs_low  += (hs0 == 1'b0) ? 1 : 0;
      act_low += (act0 == 1'b0) ? 1 : 0;
      ls_cnt  += ls0 ? 1 : 0;
    end
    check_int("line_hs_low", hs_low, 96);
    check_int("line_act_low", act_low, 160);
    check_int("line_ls_cnt", ls_cnt, 1);

    // One full frame of the small timing
    tick(1'b1, 1'b1);
    vs_hi = 0; fs_cnt = 0; ls_cnt = 0; y_max = 0;
    repeat (84) begin
      tick(1'b0, 1'b1);
      vs_hi  += vs1 ? 1 : 0;
      fs_cnt += fs1 ? 1 : 0;
      ls_cnt += ls1 ? 1 : 0;
      if (int'(y1) > y_max) y_max = int'(y1);
    end
    check_int("frame_vs_hi", vs_hi, 12);
    check_int("frame_fs_cnt", fs_cnt, 1);
    check_int("frame_ls_cnt", ls_cnt, 7);
    check_int("frame_y_max", y_max, 6);

    // Alternating enable: 20 advances over 40 clocks, single-cycle pulses only
    tick(1'b1, 1'b1);
    ls_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, (i % 2) == 0);
      ls_cnt += ls1 ? 1 : 0;
    end
    check_int("en_half_x", int'(x1), 8);
    check_int("en_half_ls", ls_cnt, 1);

    // Mid-line reset, and reset overriding a low enable
    repeat (299) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("midline_rst", got0, '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b1,
                                 ls: 1'b0, fs: 1'b0});
    repeat (50) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    check("rst_over_en", got1, '{x: 10'd0, y: 10'd0, hs: 1'b0, vs: 1'b0, act: 1'b1,
                                 ls: 1'b0, fs: 1'b0});

    // Random enable pattern across several small frames
    for (int i = 0; i < 400; i++) tick(1'b0, $urandom_range(0, 1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
